// File: rtl/aes_dec_sched.sv
// aes_dec_sched: round sequencer and two-requester round-robin arbiter for
// the iterative AES inverse-cipher datapath. Drives load / round-key index /
// final-round controls for 10, 12 or 14 rounds and reports completion.
// Optional feature macro: AES_DEC_SCHED_HOLD_EN (DONE held until done_ack_i).
module aes_dec_sched #(
  parameter int unsigned KEY_IDX_W = 4,
  parameter int unsigned NR128     = 10,
  parameter int unsigned NR192     = 12,
  parameter int unsigned NR256     = 14
) (
  input  logic                 eph1,
  input  logic                 reset,
  input  logic [1:0]           req_vld_i,
  input  logic [1:0][1:0]      req_ksz_i,
  output logic [1:0]           req_gnt_o,
  output logic                 dp_load_o,
  output logic                 dp_src_o,
  output logic [KEY_IDX_W-1:0] dp_wkey_idx_o,
  output logic [KEY_IDX_W-1:0] dp_key_idx_o,
  output logic                 dp_final_o,
  output logic                 dp_hold_o,
  output logic                 done_vld_o,
  output logic                 done_id_o,
  input  logic                 done_ack_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [KEY_IDX_W-1:0] ctr;
  logic [KEY_IDX_W-1:0] nr;
  logic                 owner;
  logic                 ptr;
  logic                 first;

  logic                 leave_done;
  logic                 can_grant;
  logic                 win;
  logic [1:0]           gnt;
  logic [KEY_IDX_W-1:0] nr_sel;

`ifdef AES_DEC_SCHED_HOLD_EN
  assign leave_done = done_ack_i;
  assign dp_hold_o  = (state == DONE) && !done_ack_i;
`else
  logic unused_ack;
  assign unused_ack = done_ack_i;
  assign leave_done = 1'b1;
  assign dp_hold_o  = 1'b0;
`endif

  assign can_grant = !reset && ((state == IDLE) || ((state == DONE) && leave_done));

  // Round-robin winner selection, grant decode and winner's round count
  always_comb begin
    win    = (req_vld_i == 2'b11) ? ptr : req_vld_i[1];
    gnt    = '0;
    nr_sel = KEY_IDX_W'(NR256);
    if (can_grant && (req_vld_i != 2'b00)) gnt[win] = 1'b1;
    case (req_ksz_i[win])
      2'b00:   nr_sel = KEY_IDX_W'(NR128);
      2'b01:   nr_sel = KEY_IDX_W'(NR192);
      default: nr_sel = KEY_IDX_W'(NR256);
    endcase
  end

  // Sequencer state, round down-counter, owner and priority pointer
  always_ff @(posedge eph1) begin
    if (reset) begin
      state <= IDLE;
      ctr   <= '0;
      nr    <= '0;
      owner <= 1'b0;
      ptr   <= 1'b0;
      first <= 1'b0;
    end else begin
      first <= 1'b0;
      case (state)
        IDLE: ;
        RUN: begin
          if (ctr == '0) state <= DONE;
          else           ctr   <= ctr - KEY_IDX_W'(1);
        end
        DONE: if (leave_done) state <= IDLE;
        default: state <= IDLE;
      endcase
      // A grant only fires in IDLE or a departing DONE, so it overrides the
      // default transition above and gives back-to-back blocks with no bubble.
      if (gnt != 2'b00) begin
        state <= RUN;
        owner <= win;
        ptr   <= ~win;
        nr    <= nr_sel;
        ctr   <= nr_sel - KEY_IDX_W'(1);
        first <= 1'b1;
      end
    end
  end

  assign req_gnt_o     = gnt;
  assign dp_load_o     = first;
  assign dp_src_o      = (state == RUN) && owner;
  assign dp_wkey_idx_o = first ? nr : '0;
  assign dp_key_idx_o  = (state == RUN) ? ctr : '0;
  assign dp_final_o    = (state == RUN) && (ctr == '0);
  assign done_vld_o    = (state == DONE);
  assign done_id_o     = (state == DONE) && owner;
  assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_aes_dec_sched.sv
// Self-checking bench for aes_dec_sched: table of single-block grants plus
// hand-written sequences (simultaneous requests, back-to-back 256-bit,
// reset mid-run, delayed ack with AES_DEC_SCHED_HOLD_EN).
module tb_aes_dec_sched;

  logic            eph1 = 1'b0;
  logic            reset;
  logic [1:0]      vld;
  logic [1:0][1:0] ksz;
  logic [1:0]      gnt;
  logic            load, src, fin, hold, dvld, did, ack, busy;
  logic [3:0]      wkey, kidx;

  aes_dec_sched #(.KEY_IDX_W(4), .NR128(10), .NR192(12), .NR256(14)) dut (
    .eph1(eph1), .reset(reset), .req_vld_i(vld), .req_ksz_i(ksz),
    .req_gnt_o(gnt), .dp_load_o(load), .dp_src_o(src), .dp_wkey_idx_o(wkey),
    .dp_key_idx_o(kidx), .dp_final_o(fin), .dp_hold_o(hold),
    .done_vld_o(dvld), .done_id_o(did), .done_ack_i(ack), .busy_o(busy)
  );

  always #5 eph1 = ~eph1;

  typedef struct { int id; int nr; int gcyc; } exp_t;
  typedef struct { logic [1:0] v; logic [1:0] k0; logic [1:0] k1; logic [1:0] g; int nr; } vec_t;

  exp_t exp_q[$];
  vec_t vt[8];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   eidx = 0;
  int   last_id = 0;
  bit   active = 0, done_due = 0, last_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input int nr);
    exp_t e;
    e.id = id; e.nr = nr; e.gcyc = cyc;
    exp_q.push_back(e);
  endtask

  // Per-cycle monitor: compares outputs against the scoreboard head
  task automatic mon();
    exp_t h;
    bit held;
    held = 1'b0;
`ifdef AES_DEC_SCHED_HOLD_EN
    held = last_done && !ack;
    chk("hold", 32'(hold), 32'(dvld && !ack));
`else
    chk("hold_zero", 32'(hold), 0);
`endif
    if (done_due) begin
      chk("done_vld", 32'(dvld), 1);
      chk("done_id", 32'(did), 32'(last_id));
      done_due = 0;
    end else if (held) begin
      chk("done_held", 32'(dvld), 1);
      chk("done_held_id", 32'(did), 32'(last_id));
    end else begin
      chk("no_done", 32'(dvld), 0);
    end
    last_done = dvld;
    if (load) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_load", 32'(load), 0);
      end else begin
        h = exp_q.pop_front();
        chk("load_latency", 32'(cyc - h.gcyc), 1);
        chk("load_src", 32'(src), 32'(h.id));
        chk("wkey_idx", 32'(wkey), 32'(h.nr));
        active = 1; eidx = h.nr - 1; last_id = h.id;
      end
    end else begin
      chk("wkey_idle", 32'(wkey), 0);
    end
    if (active) begin
      chk("key_idx", 32'(kidx), 32'(eidx));
      chk("final", 32'(fin), 32'(eidx == 0));
      chk("run_src", 32'(src), 32'(last_id));
      if (eidx == 0) begin active = 0; done_due = 1; end
      else eidx--;
    end else begin
      chk("key_idx_idle", 32'(kidx), 0);
      chk("final_idle", 32'(fin), 0);
    end
  endtask

  task automatic step();
    @(negedge eph1);
    cyc++;
    mon();
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || active || done_due) && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || active || done_due) begin
      errors++;
      $display("FAIL drain_timeout: got pending=%0d expected 0 (cycle %0d)", exp_q.size(), cyc);
      exp_q.delete(); active = 0; done_due = 0;
    end
  endtask

  initial begin
    vt[0] = '{2'b01, 2'b00, 2'b00, 2'b01, 10};
    vt[1] = '{2'b10, 2'b00, 2'b01, 2'b10, 12};
    vt[2] = '{2'b11, 2'b11, 2'b00, 2'b01, 14};
    vt[3] = '{2'b11, 2'b00, 2'b10, 2'b10, 14};
    vt[4] = '{2'b10, 2'b01, 2'b00, 2'b10, 10};
    vt[5] = '{2'b11, 2'b01, 2'b01, 2'b01, 12};
    vt[6] = '{2'b01, 2'b00, 2'b11, 2'b01, 10};
    vt[7] = '{2'b11, 2'b11, 2'b00, 2'b10, 10};

    reset = 1'b1; vld = 2'b11; ksz = '0; ack = 1'b1;
    repeat (3) step();
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load", 32'(load), 0);
    vld = 2'b00;
    reset = 1'b0;
    step();

    // Simultaneous requests after reset: req0 first, req1 granted in DONE
    vld = 2'b11; ksz[0] = 2'b00; ksz[1] = 2'b00;
    #1 chk("sim_gnt0", 32'(gnt), 32'(2'b01));
    push(0, 10);
    step();
    vld = 2'b10;
    for (int i = 0; i < 10; i++) begin
      #1 chk("sim_gnt_run", 32'(gnt), 0);
      step();
    end
    #1 chk("sim_gnt1_in_done", 32'(gnt), 32'(2'b10));
    chk("sim_busy_done", 32'(busy), 1);
    push(1, 10);
    step();
    vld = 2'b00;
    wait_drain(20);

    // Table of single-block grants; pointer carries across entries
    for (int i = 0; i < 8; i++) begin
      vld = vt[i].v; ksz[0] = vt[i].k0; ksz[1] = vt[i].k1;
      #1 chk("tbl_gnt", 32'(gnt), 32'(vt[i].g));
      push(int'(vt[i].g[1]), vt[i].nr);
      step();
      vld = 2'b00; ksz = 4'($urandom_range(0, 15));
      wait_drain(20);
    end

    // 256-bit back-to-back with req1 held
    vld = 2'b10; ksz[1] = 2'b10; ksz[0] = 2'b00;
    #1 chk("b2b_gnt_first", 32'(gnt), 32'(2'b10));
    push(1, 14);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 14; i++) begin
        step();
        #1 chk("b2b_gnt_run", 32'(gnt), 0);
      end
      step();
      if (k == 2) vld = 2'b00;
      #1 chk("b2b_gnt_done", 32'(gnt), (k < 2) ? 32'(2'b10) : 0);
      if (k < 2) push(1, 14);
    end
    wait_drain(20);

    // Reset mid-run: pointer left at 1 by the req0 grant, reset restores 0
    vld = 2'b01; ksz[0] = 2'b00;
    #1 chk("rmr_gnt", 32'(gnt), 32'(2'b01));
    push(0, 10);
    step();
    vld = 2'b00;
    repeat (4) step();
    reset = 1'b1;
    exp_q.delete(); active = 0; done_due = 0; last_done = 0;
    step();
    chk("rmr_busy", 32'(busy), 0);
    chk("rmr_load", 32'(load), 0);
    chk("rmr_kidx", 32'(kidx), 0);
    chk("rmr_src", 32'(src), 0);
    reset = 1'b0;
    repeat (12) step();
    vld = 2'b11; ksz[0] = 2'b00; ksz[1] = 2'b00;
    #1 chk("rmr_ptr_reset", 32'(gnt), 32'(2'b01));
    push(0, 10);
    step();
    vld = 2'b00;
    wait_drain(20);

`ifdef AES_DEC_SCHED_HOLD_EN
    // Delayed ack: DONE held four cycles, req1 granted in the ack cycle
    vld = 2'b01; ksz[0] = 2'b00;
    #1 chk("hold_gnt0", 32'(gnt), 32'(2'b01));
    push(0, 10);
    step();
    vld = 2'b10; ksz[1] = 2'b01; ack = 1'b0;
    repeat (10) step();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      #1;
      chk("hold_dvld", 32'(dvld), 1);
      chk("hold_hold", 32'(hold), 1);
      chk("hold_no_gnt", 32'(gnt), 0);
    end
    step();
    ack = 1'b1;
    #1;
    chk("hold_gnt1_ack", 32'(gnt), 32'(2'b10));
    chk("hold_release", 32'(hold), 0);
    push(1, 12);
    step();
    vld = 2'b00;
    wait_drain(20);
`endif

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
